cfar_frame_sequencer: RTL and testbench
=======================================

Name: cfar_frame_sequencer

Overview:
Controller that sequences one frame of power samples from a sample RAM into the CFAR detector core, on a start command. It drives the core's input_valid/power_in/index_in/eop_in/reverse stream and optionally runs a second reverse pass. It waits out the core's pipeline drain, forwards and counts detections, then reports done. It sits between the frame buffer and the CFAR core, in place of a host driving the core directly.

Parameters:
INPUT_WIDTH, 16, width of power samples (matches the CFAR core)
ADDR_WIDTH, 10, sample address/index width; maximum frame is 2**ADDR_WIDTH samples
DRAIN_CYCLES, 15, idle cycles after eop_in before a pass is considered complete
DET_CNT_WIDTH, 11, width of the detection counter

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock, asynchronous assert, active-low
start  in  1  start request; accepted only in IDLE
frame_len  in  ADDR_WIDTH+1  samples per pass; latched on accepted start
dual_pass  in  1  1 = forward pass then reverse pass; latched on start
abort  in  1  cancel the current operation
mem_rd_en  out  1  sample RAM read strobe
mem_rd_addr  out  ADDR_WIDTH  sample RAM read address
mem_rd_data  in  INPUT_WIDTH  RAM data; valid exactly 1 cycle after mem_rd_en
power_in  out  INPUT_WIDTH  sample to the CFAR core
index_in  out  ADDR_WIDTH  sample index to the core
input_valid  out  1  sample strobe to the core
eop_in  out  1  last-sample marker to the core
reverse  out  1  pass direction to the core
max_valid  in  1  core detection strobe, one cycle per detection
index_out  in  ADDR_WIDTH  core detection index
det_valid  out  1  registered copy of max_valid while busy
det_index  out  ADDR_WIDTH  registered index_out
det_pass  out  1  0 = forward pass, 1 = reverse pass, for det_valid
det_count  out  DET_CNT_WIDTH  detections in the current/last run
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse at normal completion
err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset values: all outputs 0; state IDLE; det_count 0.
- States: IDLE, STREAM, DRAIN. Pass flag: fwd/rev.
- IDLE, start=1, abort=0:
  - frame_len==0 or frame_len>2**ADDR_WIDTH -> err pulse next cycle; stay IDLE.
  - Otherwise: latch frame_len and dual_pass; clear det_count; pass=fwd; go to STREAM.
- start while busy is ignored with no err. abort and start in the same cycle in IDLE -> nothing happens.
- STREAM:
  - mem_rd_en=1 every cycle, frame_len cycles with no gaps.
  - Address order: fwd 0..N-1; rev N-1..0.
  - Each cycle after a read: input_valid=1, power_in=mem_rd_data, index_in=read address, reverse=pass flag.
  - Read-to-core latency is 1 cycle; core-visible stream is N consecutive valid cycles.
  - eop_in=1 coincident with the Nth input_valid only.
  - The cycle after the last read goes to DRAIN.
- DRAIN:
  - input_valid=0; counter runs DRAIN_CYCLES cycles counted after the eop_in cycle.
  - At expiry: if dual_pass and pass==fwd -> pass=rev, back to STREAM. Else -> IDLE with done pulse that cycle; busy low on the same edge.
- reverse holds constant for the whole pass including DRAIN. It updates only at pass start.
- Detections:
  - When busy and max_valid=1: next cycle det_valid=1, det_index=index_out, det_pass=pass flag, det_count+1.
  - det_count saturates at all-ones. max_valid in IDLE is ignored.
- det_count holds after done until the next accepted start.
- abort in STREAM or DRAIN:
  - Next cycle IDLE; mem_rd_en, input_valid, eop_in, reverse all 0.
  - In-flight read data is discarded; no done; det_count is held.
- Single-sample frame (N=1): one valid cycle with eop_in=1. Full frame N=2**ADDR_WIDTH: the address wraps cleanly, and no read beyond N occurs.

Decomposition:
- Package cfar_pkg: state enum (IDLE/STREAM/DRAIN), pass encoding, default width constants.
- Optional sub-module cfar_addr_gen: up/down address counter with load, terminal-count flag and direction input. All other logic is inline.

Test Plan:
- N=1024, dual_pass=0, RAM[i]=i: 1024 consecutive input_valid cycles with index_in 0..1023; eop_in only at index 1023; done exactly 15 cycles after the eop_in cycle +1; busy low afterwards.
- N=8, dual_pass=1: forward indices 0..7 (reverse=0), 15 idle cycles, then 7..0 with reverse=1 and eop_in at index 0; one done total.
- N=16, inject max_valid at index 3 (fwd) and 12 (rev) -> det_valid twice, det_pass 0 then 1, det_count=2.
- frame_len=0 and frame_len=1025 -> err pulse each time; busy stays 0. start while busy -> ignored.
- abort 5 cycles into STREAM -> next cycle input_valid=0, mem_rd_en=0, no done; a following start runs a clean frame from index 0.
- Assert reset_n low mid-STREAM -> all outputs 0 asynchronously; after release, IDLE with det_count=0.

Source files
------------

// File: rtl/cfar_pkg.sv
// cfar_pkg: shared state codes, pass encoding and default widths for the CFAR frame sequencer.
// No ports. Imported by cfar_addr_gen and cfar_frame_sequencer.
package cfar_pkg;
    localparam int DEF_INPUT_WIDTH   = 16;
    localparam int DEF_ADDR_WIDTH    = 10;
    localparam int DEF_DRAIN_CYCLES  = 15;
    localparam int DEF_DET_CNT_WIDTH = 11;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic PASS_FWD = 1'b0;
    localparam logic PASS_REV = 1'b1;
endpackage

// File: rtl/cfar_addr_gen.sv
// cfar_addr_gen: up/down sample address counter with load and terminal-count flag.
// Ports: clk, reset_n; load/load_val preset the counter; step advances it (down selects
// decrement); tc is high while addr equals end_val.
module cfar_addr_gen
    import cfar_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  step,
    input  logic                  down,
    input  logic [ADDR_WIDTH-1:0] end_val,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  tc
);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            addr <= '0;
        else if (load)
            addr <= load_val;
        else if (step)
            addr <= down ? addr - ONE : addr + ONE;
    end

    assign tc = addr == end_val;
endmodule

// File: rtl/cfar_frame_sequencer.sv
// cfar_frame_sequencer: streams one frame from sample RAM into the CFAR core, optionally
// a second reverse pass, waits out the core drain and forwards/counts detections.
// Ports: start/frame_len/dual_pass/abort command; mem_rd_* sample RAM read port;
// power_in/index_in/input_valid/eop_in/reverse core stream; max_valid/index_out core
// detections; det_* forwarded detections and count; busy/done/err status.
module cfar_frame_sequencer
    import cfar_pkg::*;
#(
    parameter int INPUT_WIDTH   = DEF_INPUT_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
    parameter int DET_CNT_WIDTH = DEF_DET_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH:0]      frame_len,
    input  logic                     dual_pass,
    input  logic                     abort,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [INPUT_WIDTH-1:0]   mem_rd_data,
    output logic [INPUT_WIDTH-1:0]   power_in,
    output logic [ADDR_WIDTH-1:0]    index_in,
    output logic                     input_valid,
    output logic                     eop_in,
    output logic                     reverse,
    input  logic                     max_valid,
    input  logic [ADDR_WIDTH-1:0]    index_out,
    output logic                     det_valid,
    output logic [ADDR_WIDTH-1:0]    det_index,
    output logic                     det_pass,
    output logic [DET_CNT_WIDTH-1:0] det_count,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [DW-1:0] D_END = DW'(DRAIN_CYCLES);
    localparam logic [DET_CNT_WIDTH-1:0] CNT_ONE = DET_CNT_WIDTH'(1);

    logic [1:0]            st;
    logic [ADDR_WIDTH-1:0] len_m1;
    logic                  dual;
    logic                  pass;
    logic [DW-1:0]         dcnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  tc;
    logic                  len_ok;
    logic                  accept;
    logic                  streaming;
    logic                  drain_end;
    logic                  rev_start;

    assign len_ok    = frame_len != '0 && frame_len <= MAX_LEN;
    assign accept    = st == ST_IDLE && start && !abort && len_ok;
    assign streaming = st == ST_STREAM && !abort;
    // dcnt is 0 in the eop_in cycle, so expiry lands DRAIN_CYCLES cycles after it
    assign drain_end = st == ST_DRAIN && !abort && dcnt == D_END;
    assign rev_start = drain_end && dual && pass == PASS_FWD;

    assign busy        = st != ST_IDLE;
    assign mem_rd_en   = st == ST_STREAM;
    assign mem_rd_addr = addr;
    // RAM data arrives the cycle after the read, exactly when input_valid is up
    assign power_in    = input_valid ? mem_rd_data : '0;
    assign reverse     = pass;

    cfar_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept || rev_start),
        .load_val (accept ? '0 : len_m1),
        .step     (streaming && !tc),
        .down     (pass),
        .end_val  (pass ? '0 : len_m1),
        .addr     (addr),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= ST_IDLE;
            len_m1      <= '0;
            dual        <= 1'b0;
            pass        <= PASS_FWD;
            dcnt        <= '0;
            input_valid <= 1'b0;
            index_in    <= '0;
            eop_in      <= 1'b0;
            det_valid   <= 1'b0;
            det_index   <= '0;
            det_pass    <= 1'b0;
            det_count   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            input_valid <= streaming;
            index_in    <= streaming ? addr : '0;
            eop_in      <= streaming && tc;
            done        <= drain_end && !rev_start;
            err         <= st == ST_IDLE && start && !abort && !len_ok;
            det_valid   <= busy && max_valid;
            if (busy && max_valid) begin
                det_index <= index_out;
                det_pass  <= pass;
            end
            if (accept)
                det_count <= '0;
            else if (busy && max_valid && det_count != '1)
                det_count <= det_count + CNT_ONE;
            if (accept) begin
                st     <= ST_STREAM;
                len_m1 <= ADDR_WIDTH'(frame_len - LW'(1));
                dual   <= dual_pass;
                pass   <= PASS_FWD;
            end else if ((busy && abort) || (drain_end && !rev_start)) begin
                st   <= ST_IDLE;
                pass <= PASS_FWD;
            end else if (rev_start) begin
                st   <= ST_STREAM;
                pass <= PASS_REV;
            end else if (streaming && tc) begin
                st   <= ST_DRAIN;
                dcnt <= '0;
            end else if (st == ST_DRAIN) begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end
endmodule

// File: tb/tb_cfar_frame_sequencer.sv
// tb_cfar_frame_sequencer: self-checking bench for cfar_frame_sequencer with a RAM model and expected-stream queues.
module tb_cfar_frame_sequencer;
    localparam int IW = 16;
    localparam int AW = 10;
    localparam int DC = 15;
    localparam int CW = 11;
    localparam int LW = AW + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic dual_pass = 1'b0;
    logic abort = 1'b0;
    logic max_valid = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [AW-1:0] index_out = '0;
    logic [IW-1:0] mem_rd_data = '0;
    logic [AW-1:0] mem_rd_addr, index_in, det_index;
    logic [IW-1:0] power_in;
    logic mem_rd_en, input_valid, eop_in, reverse, det_valid, det_pass, busy, done, err;
    logic [CW-1:0] det_count;
    logic [65:0] all_out;

    int passed = 0;
    int total = 0;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [IW-1:0] pw;
        logic          eop;
        logic          rev;
    } smp_t;
    typedef struct packed {
        logic [AW-1:0] idx;
        logic          pass;
    } det_t;

    smp_t sq[$];
    det_t dq[$];

    always #5 clk = ~clk;

    cfar_frame_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .frame_len   (frame_len),
        .dual_pass   (dual_pass),
        .abort       (abort),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .power_in    (power_in),
        .index_in    (index_in),
        .input_valid (input_valid),
        .eop_in      (eop_in),
        .reverse     (reverse),
        .max_valid   (max_valid),
        .index_out   (index_out),
        .det_valid   (det_valid),
        .det_index   (det_index),
        .det_pass    (det_pass),
        .det_count   (det_count),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    assign all_out = {mem_rd_en, mem_rd_addr, power_in, index_in, input_valid, eop_in, reverse,
                      det_valid, det_index, det_pass, det_count, busy, done, err};

    function automatic logic [IW-1:0] ram(input logic [AW-1:0] a);
        return IW'(a) * IW'(3) + IW'(7);
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram(mem_rd_addr);

    task automatic push_pass(input int n, input logic rev);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = rev ? AW'(n - 1 - i) : AW'(i);
            sq.push_back({a, ram(a), i == n - 1, rev});
        end
    endtask

    task automatic start_frame(input int n, input logic dual);
        @(negedge clk);
        start = 1'b1;
        frame_len = LW'(n);
        dual_pass = dual;
        @(negedge clk);
        start = 1'b0;
        dual_pass = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (all_out !== '0) $display("FAIL reset_outputs got %h want 0", all_out); else passed++;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (all_out !== '0) $display("FAIL idle_after_reset got %h want 0", all_out); else passed++;
    endtask

    task automatic test_single_pass(input int n);
        int e = -1;
        int d = -1;
        int reads = 0;
        smp_t got, exp;
        sq.delete();
        push_pass(n, 1'b0);
        start_frame(n, 1'b0);
        for (int c = 0; c < n + 100 && d < 0; c++) begin
            if (mem_rd_en) reads++;
            if (input_valid) begin
                got = {index_in, power_in, eop_in, reverse};
                exp = (sq.size() > 0) ? sq.pop_front() : '1;
                total++;
                if (got !== exp) $display("FAIL stream n=%0d c=%0d got %h want %h", n, c, got, exp); else passed++;
                if (eop_in) e = c;
            end
            if (done) begin
                d = c;
                total++;
                if (busy !== 1'b0) $display("FAIL busy_at_done n=%0d got %b want 0", n, busy); else passed++;
            end
            @(negedge clk);
        end
        total++;
        if (d - e !== DC + 1) $display("FAIL done_latency n=%0d got %0d want %0d", n, d - e, DC + 1); else passed++;
        total++;
        if (reads !== n) $display("FAIL read_count n=%0d got %0d want %0d", n, reads, n); else passed++;
        total++;
        if (sq.size() !== 0) $display("FAIL stream_left n=%0d got %0d want 0", n, sq.size()); else passed++;
        total++;
        if ({done, busy} !== 2'b00) $display("FAIL after_done n=%0d got %b want 00", n, {done, busy}); else passed++;
    endtask

    task automatic test_dual;
        int e1 = -1;
        int e2 = -1;
        int fr = -1;
        int d = -1;
        int dones = 0;
        int reads = 0;
        int rev_bad = 0;
        smp_t got, exp;
        sq.delete();
        push_pass(8, 1'b0);
        push_pass(8, 1'b1);
        start_frame(8, 1'b1);
        for (int c = 0; c < 90; c++) begin
            if (mem_rd_en) reads++;
            if (busy && reverse !== (e1 >= 0 && c >= e1 + DC + 1)) rev_bad++;
            if (input_valid) begin
                got = {index_in, power_in, eop_in, reverse};
                exp = (sq.size() > 0) ? sq.pop_front() : '1;
                total++;
                if (got !== exp) $display("FAIL dual_stream c=%0d got %h want %h", c, got, exp); else passed++;
                if (e1 >= 0 && fr < 0) fr = c;
                if (eop_in && e1 < 0) e1 = c;
                else if (eop_in) e2 = c;
            end
            if (done) begin
                dones++;
                d = c;
            end
            @(negedge clk);
        end
        total++;
        if (dones !== 1) $display("FAIL dual_done_count got %0d want 1", dones); else passed++;
        total++;
        if (d - e2 !== DC + 1) $display("FAIL dual_done_latency got %0d want %0d", d - e2, DC + 1); else passed++;
        total++;
        if (fr - e1 !== DC + 2) $display("FAIL dual_pass_gap got %0d want %0d", fr - e1, DC + 2); else passed++;
        total++;
        if (reads !== 16) $display("FAIL dual_reads got %0d want 16", reads); else passed++;
        total++;
        if (rev_bad !== 0) $display("FAIL reverse_hold got %0d bad cycles want 0", rev_bad); else passed++;
        total++;
        if (sq.size() !== 0) $display("FAIL dual_stream_left got %0d want 0", sq.size()); else passed++;
    endtask

    task automatic test_detect;
        int nv = 0;
        int dets = 0;
        int d = -1;
        det_t got, exp;
        dq.delete();
        dq.push_back('{idx: 10'd3, pass: 1'b0});
        dq.push_back('{idx: 10'd12, pass: 1'b1});
        start_frame(16, 1'b1);
        for (int c = 0; c < 150 && d < 0; c++) begin
            if (det_valid) begin
                got = {det_index, det_pass};
                exp = (dq.size() > 0) ? dq.pop_front() : '1;
                total++;
                if (got !== exp) $display("FAIL detection c=%0d got %h want %h", c, got, exp); else passed++;
                dets++;
            end
            if (done) d = c;
            max_valid = input_valid && ((nv < 16 && index_in == 10'd3) || (nv >= 16 && index_in == 10'd12));
            index_out = index_in;
            if (input_valid) nv++;
            @(negedge clk);
        end
        max_valid = 1'b0;
        total++;
        if (dets !== 2) $display("FAIL det_events got %0d want 2", dets); else passed++;
        total++;
        if (det_count !== CW'(2)) $display("FAIL det_count got %0d want 2", det_count); else passed++;
        max_valid = 1'b1;
        index_out = 10'd5;
        @(negedge clk);
        max_valid = 1'b0;
        total++;
        if ({det_valid, det_count} !== {1'b0, CW'(2)}) $display("FAIL idle_max_valid got %b/%0d want 0/2", det_valid, det_count); else passed++;
    endtask

    task automatic test_reject;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1;
            abort = i == 2;
            frame_len = (i == 0) ? LW'(0) : (i == 1) ? LW'(1025) : LW'(8);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            total++;
            if ({err, busy} !== {i < 2, 1'b0}) $display("FAIL reject_%0d got err/busy %b want %b", i, {err, busy}, {i < 2, 1'b0}); else passed++;
            @(negedge clk);
            total++;
            if ({err, busy} !== 2'b00) $display("FAIL reject_pulse_%0d got err/busy %b want 00", i, {err, busy}); else passed++;
        end
    endtask

    task automatic test_busy_start;
        int d = -1;
        int errs = 0;
        smp_t got, exp;
        sq.delete();
        push_pass(8, 1'b0);
        start_frame(8, 1'b0);
        for (int c = 0; c < 60 && d < 0; c++) begin
            if (err) errs++;
            if (input_valid) begin
                got = {index_in, power_in, eop_in, reverse};
                exp = (sq.size() > 0) ? sq.pop_front() : '1;
                total++;
                if (got !== exp) $display("FAIL busy_start_stream c=%0d got %h want %h", c, got, exp); else passed++;
            end
            if (done) d = c;
            start = c == 1 || c == 3;
            frame_len = (c == 1) ? LW'(0) : LW'(4);
            dual_pass = c == 3;
            @(negedge clk);
        end
        start = 1'b0;
        dual_pass = 1'b0;
        total++;
        if (errs !== 0) $display("FAIL busy_start_err got %0d want 0", errs); else passed++;
        total++;
        if (d < 0 || sq.size() !== 0) $display("FAIL busy_start_frame got done=%0d left=%0d want done and 0 left", d, sq.size()); else passed++;
    endtask

    task automatic test_abort;
        int dn = 0;
        int d = -1;
        smp_t got, exp;
        start_frame(32, 1'b0);
        for (int c = 0; c < 40; c++) begin
            if (c == 6) begin
                total++;
                if ({mem_rd_en, input_valid, eop_in, reverse, busy} !== 5'b0)
                    $display("FAIL abort_outputs got %b want 00000", {mem_rd_en, input_valid, eop_in, reverse, busy});
                else passed++;
                total++;
                if (det_count !== CW'(1)) $display("FAIL abort_det_count got %0d want 1", det_count); else passed++;
            end
            if (done) dn++;
            max_valid = c == 2;
            index_out = 10'd7;
            abort = c == 5;
            @(negedge clk);
        end
        max_valid = 1'b0;
        abort = 1'b0;
        total++;
        if (dn !== 0) $display("FAIL abort_done got %0d want 0", dn); else passed++;
        sq.delete();
        push_pass(4, 1'b0);
        start_frame(4, 1'b0);
        for (int c = 0; c < 60 && d < 0; c++) begin
            if (input_valid) begin
                got = {index_in, power_in, eop_in, reverse};
                exp = (sq.size() > 0) ? sq.pop_front() : '1;
                total++;
                if (got !== exp) $display("FAIL post_abort_stream c=%0d got %h want %h", c, got, exp); else passed++;
            end
            if (done) d = c;
            @(negedge clk);
        end
        total++;
        if (d < 0 || sq.size() !== 0) $display("FAIL post_abort_frame got done=%0d left=%0d want done and 0 left", d, sq.size()); else passed++;
    endtask

    task automatic test_async_reset;
        start_frame(64, 1'b1);
        for (int c = 0; c < 10; c++) begin
            max_valid = c == 2;
            @(negedge clk);
        end
        max_valid = 1'b0;
        total++;
        if ({det_count, busy} !== {CW'(1), 1'b1}) $display("FAIL pre_reset got %0d/%b want 1/1", det_count, busy); else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (all_out !== '0) $display("FAIL async_reset got %h want 0", all_out); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, det_count, done, err, mem_rd_en} !== '0) $display("FAIL post_reset got %b want 0", {busy, det_count, done, err, mem_rd_en}); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_pass(1024);
        test_single_pass(1);
        test_dual;
        test_detect;
        test_reject;
        test_busy_start;
        test_abort;
        test_async_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
